fetch_pair_queue: RTL and testbench

Dual-issue instruction queue between the OTTER fetch stage and the dual-instruction decoder. Accepts up to two fetched instruction/PC pairs per cycle, buffers them in a circular FIFO, and presents the two oldest entries in program order as decode slots 0 and 1. On a redirect (branch, jump, or trap), it flushes all contents.

---
 rtl/fetch_pair_queue.sv | 130 +++++++++++++
 tb/tb_fetch_pair_queue.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pair_queue.sv
// Dual-issue instruction queue between fetch and the dual-instruction decoder.
// Circular FIFO of {PC, IR} entries; accepts up to two entries per cycle and
// presents the two oldest entries in program order as decode slots 0 and 1.
module fetch_pair_queue #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid_0,
  input  logic                     in_valid_1,
  input  logic [31:0]              in_pc_0,
  input  logic [31:0]              in_pc_1,
  input  logic [31:0]              in_ir_0,
  input  logic [31:0]              in_ir_1,
  output logic                     in_ready,
  output logic                     out_valid_0,
  output logic                     out_valid_1,
  output logic [31:0]              out_pc_0,
  output logic [31:0]              out_pc_1,
  output logic [31:0]              out_ir_0,
  output logic [31:0]              out_ir_1,
  input  logic [1:0]               out_take,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] ReadyMax = CW'(DEPTH - 2);
  localparam logic [31:0]   NopIr    = 32'h0000_0013;

  logic [31:0] pc_mem [DEPTH];
  logic [31:0] ir_mem [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [AW-1:0] head_p1;
  logic [AW-1:0] tail_p1;
  logic [1:0]    enq;
  logic [1:0]    deq;
  logic [1:0]    take_eff;
  logic          wr_en_0;
  logic          wr_en_1;

  // Slot 1 addresses wrap independently of slot 0.
  assign head_p1 = head_q + AW'(1);
  assign tail_p1 = tail_q + AW'(1);

  // Ready depends only on registered occupancy: no decode-to-fetch path.
  assign in_ready = (count_q <= ReadyMax);
  assign count    = count_q;

  // Enqueue/dequeue amounts; slot 1 without slot 0 is ignored.
  always_comb begin
    enq      = 2'd0;
    deq      = 2'd0;
    take_eff = (out_take == 2'd3) ? 2'd2 : out_take;
    if (in_ready && in_valid_0) begin
      enq = in_valid_1 ? 2'd2 : 2'd1;
    end
    if (count_q == '0) begin
      deq = 2'd0;
    end else if (count_q == CW'(1)) begin
      deq = (take_eff != 2'd0) ? 2'd1 : 2'd0;
    end else begin
      deq = take_eff;
    end
  end

  assign wr_en_0 = !flush && (enq != 2'd0);
  assign wr_en_1 = !flush && (enq == 2'd2);

  // Next-state pointers and occupancy; flush overrides everything.
  always_comb begin
    head_d  = head_q + AW'(deq);
    tail_d  = tail_q + AW'(enq);
    count_d = count_q + CW'(enq) - CW'(deq);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Pointer and occupancy registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage writes; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en_0) begin
      pc_mem[tail_q] <= in_pc_0;
      ir_mem[tail_q] <= in_ir_0;
    end
    if (wr_en_1) begin
      pc_mem[tail_p1] <= in_pc_1;
      ir_mem[tail_p1] <= in_ir_1;
    end
  end

  // Decode slot outputs; invalid slots present PC 0 and a NOP.
  always_comb begin
    out_valid_0 = (count_q != '0);
    out_valid_1 = (count_q >= CW'(2));
    out_pc_0    = 32'h0;
    out_ir_0    = NopIr;
    out_pc_1    = 32'h0;
    out_ir_1    = NopIr;
    if (out_valid_0) begin
      out_pc_0 = pc_mem[head_q];
      out_ir_0 = ir_mem[head_q];
    end
    if (out_valid_1) begin
      out_pc_1 = pc_mem[head_p1];
      out_ir_1 = ir_mem[head_p1];
    end
  end

endmodule

// File: tb/tb_fetch_pair_queue.sv
// Scoreboard bench for fetch_pair_queue: stimulus pushes expected entries,
// a forked monitor pops and compares whatever the decoder consumes.
module tb_fetch_pair_queue;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid_0 = 1'b0;
  logic        in_valid_1 = 1'b0;
  logic [31:0] in_pc_0 = '0;
  logic [31:0] in_pc_1 = '0;
  logic [31:0] in_ir_0 = '0;
  logic [31:0] in_ir_1 = '0;
  logic        in_ready;
  logic        out_valid_0;
  logic        out_valid_1;
  logic [31:0] out_pc_0;
  logic [31:0] out_pc_1;
  logic [31:0] out_ir_0;
  logic [31:0] out_ir_1;
  logic [1:0]  out_take = '0;
  logic        flush = 1'b0;
  logic [3:0]  count;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } ent_t;

  ent_t exp_q[$];
  int   pend;
  int   checks;
  int   failures;

  fetch_pair_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid_0 (in_valid_0),
    .in_valid_1 (in_valid_1),
    .in_pc_0    (in_pc_0),
    .in_pc_1    (in_pc_1),
    .in_ir_0    (in_ir_0),
    .in_ir_1    (in_ir_1),
    .in_ready   (in_ready),
    .out_valid_0(out_valid_0),
    .out_valid_1(out_valid_1),
    .out_pc_0   (out_pc_0),
    .out_pc_1   (out_pc_1),
    .out_ir_0   (out_ir_0),
    .out_ir_1   (out_ir_1),
    .out_take   (out_take),
    .flush      (flush),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // One clock of stimulus, entered and left at posedge+1.
  task automatic cycle(input logic v0, input logic v1,
                       input logic [31:0] pc0, input logic [31:0] ir0,
                       input logic [31:0] pc1, input logic [31:0] ir1,
                       input logic [1:0] take, input logic fl, output logic acc);
    logic mready;
    check("count", 32'(count), 32'(exp_q.size()));
    mready = (int'(DEPTH) - exp_q.size()) >= 2;
    check("in_ready", 32'(in_ready), 32'(mready));
    in_valid_0 = v0;
    in_valid_1 = v1;
    in_pc_0    = pc0;
    in_ir_0    = ir0;
    in_pc_1    = pc1;
    in_ir_1    = ir1;
    out_take   = take;
    flush      = fl;
    pend       = 0;
    acc        = 1'b0;
    if (!fl && mready && v0) begin
      exp_q.push_back({pc0, ir0});
      pend = 1;
      acc  = 1'b1;
      if (v1) begin
        exp_q.push_back({pc1, ir1});
        pend = 2;
      end
    end
    @(posedge clk);
    #1;
    if (fl) exp_q.delete();
    pend       = 0;
    in_valid_0 = 1'b0;
    in_valid_1 = 1'b0;
    out_take   = 2'd0;
    flush      = 1'b0;
  endtask

  task automatic idle(input logic [1:0] take);
    logic acc;
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, take, 1'b0, acc);
  endtask

  task automatic pair(input logic [31:0] pc, input logic [1:0] take, output logic acc);
    cycle(1'b1, 1'b1, pc, pc ^ 32'hA5A5_0000, pc + 32'd4, (pc + 32'd4) ^ 32'hA5A5_0000,
          take, 1'b0, acc);
  endtask

  task automatic single(input logic [31:0] pc, input logic [1:0] take);
    logic acc;
    cycle(1'b1, 1'b0, pc, pc ^ 32'hA5A5_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, take, 1'b0, acc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid0"}, 32'(out_valid_0), 32'd0);
    check({tag, "_valid1"}, 32'(out_valid_1), 32'd0);
    check({tag, "_pc0"}, out_pc_0, 32'h0);
    check({tag, "_pc1"}, out_pc_1, 32'h0);
    check({tag, "_ir0"}, out_ir_0, 32'h0000_0013);
    check({tag, "_ir1"}, out_ir_1, 32'h0000_0013);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic        acc;
    logic [31:0] pc;
    int          n;
    checks   = 0;
    failures = 0;
    pend     = 0;

    // Monitor: pops every entry the decoder consumes at the coming edge.
    fork
      forever begin
        @(negedge clk);
        if (!rst && !flush) begin
          int   t;
          int   avail;
          ent_t e;
          t     = (out_take == 2'd3) ? 2 : int'(out_take);
          avail = exp_q.size() - pend;
          if (t > avail) t = avail;
          for (int k = 0; k < t; k++) begin
            e = exp_q.pop_front();
            if (k == 0) begin
              check("slot0_valid", 32'(out_valid_0), 32'd1);
              check("slot0_pc", out_pc_0, e.pc);
              check("slot0_ir", out_ir_0, e.ir);
            end else begin
              check("slot1_valid", 32'(out_valid_1), 32'd1);
              check("slot1_pc", out_pc_1, e.pc);
              check("slot1_ir", out_ir_1, e.ir);
            end
          end
        end
      end
    join_none

    // Reset values.
    #1 rst = 1'b1;
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // First pair visible one cycle later.
    cycle(1'b1, 1'b1, 32'h0, 32'h0050_0093, 32'h4, 32'h00A0_0113, 2'd0, 1'b0, acc);
    check("t1_valid0", 32'(out_valid_0), 32'd1);
    check("t1_valid1", 32'(out_valid_1), 32'd1);
    check("t1_pc0", out_pc_0, 32'h0);
    check("t1_pc1", out_pc_1, 32'h4);
    check("t1_ir0", out_ir_0, 32'h0050_0093);
    check("t1_ir1", out_ir_1, 32'h00A0_0113);
    check("t1_count", 32'(count), 32'd2);
    idle(2'd2);

    // Fill to DEPTH, then offered pairs are refused.
    for (int i = 0; i < 4; i++) pair(32'h1000 + 32'(i * 8), 2'd0, acc);
    check("full_count", 32'(count), 32'd8);
    check("full_ready", 32'(in_ready), 32'd0);
    pair(32'h2000, 2'd0, acc);
    check("full_hold", 32'(count), 32'd8);
    idle(2'd2);
    check("after_take2_count", 32'(count), 32'd6);
    check("after_take2_ready", 32'(in_ready), 32'd1);
    single(32'h1100, 2'd0);
    check("cnt7_ready", 32'(in_ready), 32'd0);
    pair(32'h2100, 2'd2, acc);
    check("cnt7_take2", 32'(count), 32'd5);
    for (int i = 0; i < 3; i++) idle(2'd2);

    // Continuous flow across the index wrap with take alternating 1 and 2.
    pc = 32'h0;
    n  = 0;
    for (int c = 0; c < 200 && n < 20; c++) begin
      pair(pc, (c % 2 == 0) ? 2'd1 : 2'd2, acc);
      if (acc) begin
        n++;
        pc = pc + 32'd8;
      end
    end
    for (int i = 0; i < 6; i++) idle(2'd2);
    check("wrap_drained", 32'(count), 32'd0);

    // Single-slot fetch concurrent with a single take.
    single(32'h3C, 2'd0);
    single(32'h40, 2'd1);
    check("single_count", 32'(count), 32'd1);
    check("single_pc0", out_pc_0, 32'h40);
    check("single_valid1", 32'(out_valid_1), 32'd0);
    check("single_ir1", out_ir_1, 32'h0000_0013);
    check("single_pc1", out_pc_1, 32'h0);
    idle(2'd1);

    // Slot 1 without slot 0 is ignored.
    cycle(1'b0, 1'b1, 32'h0, 32'h0, 32'h50, 32'h1, 2'd0, 1'b0, acc);
    check("illegal_count", 32'(count), 32'd0);
    check("illegal_valid0", 32'(out_valid_0), 32'd0);

    // Flush overrides a concurrent enqueue and dequeue.
    pair(32'h80, 2'd0, acc);
    pair(32'h88, 2'd0, acc);
    single(32'h90, 2'd0);
    check("preflush_count", 32'(count), 32'd5);
    cycle(1'b1, 1'b1, 32'hA0, 32'h1, 32'hA4, 32'h2, 2'd2, 1'b1, acc);
    check("flush_count", 32'(count), 32'd0);
    check("flush_valid0", 32'(out_valid_0), 32'd0);
    check("flush_valid1", 32'(out_valid_1), 32'd0);
    pair(32'h100, 2'd0, acc);
    check("postflush_pc0", out_pc_0, 32'h100);
    check("postflush_pc1", out_pc_1, 32'h104);
    idle(2'd2);

    // Take of 3 behaves as min(2, count).
    single(32'h200, 2'd0);
    idle(2'd3);
    check("take3_count", 32'(count), 32'd0);
    single(32'h204, 2'd0);
    check("take3_head_pc0", out_pc_0, 32'h204);
    pair(32'h300, 2'd0, acc);

    // Asynchronous reset mid-stream, observed before the next edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    idle(2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
